// File: rtl/farm_pkg.sv
// Shared types and the crop threshold table for the irrigation scheduler.
package farm_pkg;

  typedef enum logic [1:0] {
    PROF_RADISH  = 2'd0,
    PROF_BASIL   = 2'd1,
    PROF_LETTUCE = 2'd2,
    PROF_TOMATO  = 2'd3
  } profile_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WATER = 2'd1,
    ST_COOL  = 2'd2
  } state_e;

  // 4-bit base thresholds; the top scales them up to the sensor width.
  typedef struct packed {
    logic [3:0] dry_lo;
    logic [3:0] wet_hi;
    logic [3:0] heat_on;
    logic [3:0] heat_off;
  } thresh_t;

  // Threshold table indexed by crop profile.
  function automatic thresh_t profile_thresh(input profile_e p);
    thresh_t t;
    case (p)
      PROF_RADISH:  t = '{dry_lo: 4'd6, wet_hi: 4'd10, heat_on: 4'd4, heat_off: 4'd6};
      PROF_BASIL:   t = '{dry_lo: 4'd5, wet_hi: 4'd9,  heat_on: 4'd6, heat_off: 4'd8};
      PROF_LETTUCE: t = '{dry_lo: 4'd8, wet_hi: 4'd12, heat_on: 4'd3, heat_off: 4'd5};
      default:      t = '{dry_lo: 4'd5, wet_hi: 4'd10, heat_on: 4'd7, heat_off: 4'd9};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/farm_tick_gen.sv
// Scheduler prescaler: one-clock tick every TICK_DIV enabled clocks.
module farm_tick_gen #(
  parameter int TICK_DIV = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last = (cnt_q == CW'(TICK_DIV - 1));
  assign tick = ena & last;

  // Next phase: wrap at the last count.
  always_comb begin
    cnt_d = last ? '0 : cnt_q + 1'b1;
  end

  // Phase register, frozen while disabled.
  always_ff @(posedge clk) begin
    if (!rst_n)   cnt_q <= '0;
    else if (ena) cnt_q <= cnt_d;
  end

endmodule

// File: rtl/farm_zone_scheduler.sv
// Round-robin irrigation scheduler with watering timeout, pump cooldown
// and a hysteretic heater controller.
module farm_zone_scheduler
  import farm_pkg::*;
#(
  parameter int NUM_ZONES = 4,
  parameter int SENSOR_W  = 4,
  parameter int TICK_DIV  = 25000,
  parameter int MAX_ON    = 15,
  parameter int COOLDOWN  = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [NUM_ZONES*SENSOR_W-1:0] soil_in,
  input  logic [SENSOR_W-1:0]           temp_in,
  input  logic [1:0]                    profile,
  input  logic                          override,
  input  logic                          fault_clr,
  output logic [NUM_ZONES-1:0]          pump_out,
  output logic                          heater_out,
  output logic [NUM_ZONES-1:0]          fault_out,
  output logic                          busy
);

  localparam int ZW      = $clog2(NUM_ZONES);
  localparam int CNT_MAX = (MAX_ON > COOLDOWN) ? MAX_ON : COOLDOWN;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int SH      = SENSOR_W - 4;

  logic tick;

  farm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .tick  (tick)
  );

  state_e               state_q, state_d;
  logic [ZW-1:0]        grant_q, grant_d;
  logic [ZW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [NUM_ZONES-1:0] pump_q, pump_d;
  logic [NUM_ZONES-1:0] fault_q, fault_d;
  logic                 heater_q, heater_d;
  logic                 busy_q, busy_d;

  // Profile thresholds scaled to the sensor code width.
  thresh_t             th;
  logic [SENSOR_W-1:0] dry_lo, wet_hi, heat_on, heat_off;

  assign th       = profile_thresh(profile_e'(profile));
  assign dry_lo   = SENSOR_W'(th.dry_lo)   << SH;
  assign wet_hi   = SENSOR_W'(th.wet_hi)   << SH;
  assign heat_on  = SENSOR_W'(th.heat_on)  << SH;
  assign heat_off = SENSOR_W'(th.heat_off) << SH;

  logic [SENSOR_W-1:0]  soil [NUM_ZONES];
  logic [NUM_ZONES-1:0] req;

  generate
    for (genvar gi = 0; gi < NUM_ZONES; gi++) begin : g_zone
      assign soil[gi] = soil_in[gi*SENSOR_W +: SENSOR_W];
      assign req[gi]  = (soil[gi] < dry_lo) && !fault_q[gi] && !override;
    end
  endgenerate

  // First requesting zone at or after rr_ptr; descending scan so the
  // nearest candidate is written last.
  int            rr_sum;
  logic [ZW-1:0] cand, pick;
  logic          any_req;

  always_comb begin
    rr_sum  = 0;
    cand    = '0;
    pick    = '0;
    any_req = 1'b0;
    for (int k = NUM_ZONES - 1; k >= 0; k--) begin
      rr_sum = int'(rr_ptr_q) + k;
      if (rr_sum >= NUM_ZONES) rr_sum = rr_sum - NUM_ZONES;
      cand = ZW'(rr_sum);
      if (req[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  // Scheduler next state; override dominates, decisions only on ticks.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    pump_d   = pump_q;
    fault_d  = fault_clr ? '0 : fault_q;
    cnt_inc  = cnt_q + 1'b1;
    if (override) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pump_d  = '0;
    end else if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            grant_d       = pick;
            pump_d        = '0;
            pump_d[pick]  = 1'b1;
            cnt_d         = '0;
            state_d       = ST_WATER;
          end
        end
        ST_WATER: begin
          if (soil[grant_q] >= wet_hi) begin
            state_d = ST_COOL;
            pump_d  = '0;
            cnt_d   = '0;
          end else if (cnt_inc == CW'(MAX_ON)) begin
            fault_d[grant_q] = 1'b1;
            state_d          = ST_COOL;
            pump_d           = '0;
            cnt_d            = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_COOL: begin
          if (cnt_inc == CW'(COOLDOWN)) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            rr_ptr_d = (grant_q == ZW'(NUM_ZONES - 1)) ? '0 : grant_q + 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          pump_d  = '0;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Heater hysteresis, evaluated every enabled clock.
  always_comb begin
    heater_d = heater_q;
    if (override)                heater_d = 1'b0;
    else if (temp_in < heat_on)  heater_d = 1'b1;
    else if (temp_in >= heat_off) heater_d = 1'b0;
  end

  // All state and registered outputs; disabled clocks hold everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      pump_q   <= '0;
      fault_q  <= '0;
      heater_q <= 1'b0;
      busy_q   <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      pump_q   <= pump_d;
      fault_q  <= fault_d;
      heater_q <= heater_d;
      busy_q   <= busy_d;
    end
  end

  assign pump_out   = pump_q;
  assign fault_out  = fault_q;
  assign heater_out = heater_q;
  assign busy       = busy_q;

endmodule
